// File: rtl/mque_pff_pkg.sv
// =============================================================================
// Module      : mque_pff_pkg
// Description : Shared helpers for the multi-queue FIFO (level slice offsets).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mque_pff_pkg;

    // LSB position of queue 'port' within the packed level bus
    function automatic int lvl_lsb(input int port, input int lvl_width);
        return port * lvl_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdpramb_dclk.sv
// =============================================================================
// Module      : sdpramb_dclk
// Description : Simple dual-port RAM, independent write/read clocks, registered read.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module sdpramb_dclk #(
    parameter int WADDR      = 9,
    parameter int RADDR      = 9,
    parameter int DATA_WIDTH = 72
) (
    input  wire logic                  i_wclk,
    input  wire logic                  i_wen,
    input  wire logic [WADDR-1:0]      i_waddr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    input  wire logic                  i_rclk,
    input  wire logic                  i_ren,
    input  wire logic [RADDR-1:0]      i_raddr,
    output logic      [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**WADDR];

    always_ff @(posedge i_wclk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_rclk) begin
        if (i_ren) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mque_pff.sv
// =============================================================================
// Module      : mque_pff
// Description : PORT_NUM queues sharing one SDP RAM, per-queue level/flags/flush.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mque_pff
    import mque_pff_pkg::*;
#(
    parameter  int DATA_WIDTH = 72,
    parameter  int PORT_WIDTH = 2,
    parameter  int PORT_NUM   = 4,
    parameter  int QDEPTH_BIT = 7,
    parameter  int AF_LEVEL   = (1 << QDEPTH_BIT) - 16,
    localparam int LVL_WIDTH  = QDEPTH_BIT + 1
) (
    input  wire logic                          clks,
    input  wire logic                          reset,
    input  wire logic                          wr,
    input  wire logic [PORT_WIDTH-1:0]         wport,
    input  wire logic [DATA_WIDTH-1:0]         wdata,
    input  wire logic                          rd,
    input  wire logic [PORT_WIDTH-1:0]         rport,
    input  wire logic [PORT_NUM-1:0]           flush,
    output logic      [DATA_WIDTH-1:0]         rdata,
    output logic                               rvld,
    output logic      [PORT_WIDTH-1:0]         rvld_port,
    output logic      [PORT_NUM-1:0]           ef,
    output logic      [PORT_NUM-1:0]           af,
    output logic      [PORT_NUM-1:0]           ff,
    output logic      [PORT_NUM-1:0]           overflow,
    output logic      [PORT_NUM-1:0]           underflow,
    output logic      [LVL_WIDTH*PORT_NUM-1:0] level
);

    localparam int c_DEPTH = 1 << QDEPTH_BIT;
    localparam int c_AW    = PORT_WIDTH + QDEPTH_BIT;

    logic [PORT_NUM-1:0]   w_wacc;
    logic [PORT_NUM-1:0]   w_racc;
    logic [QDEPTH_BIT-1:0] w_wptr [PORT_NUM];
    logic [QDEPTH_BIT-1:0] w_rptr [PORT_NUM];

    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [c_AW-1:0]       w_ram_waddr;
    logic [c_AW-1:0]       w_ram_raddr;
    logic [DATA_WIDTH-1:0] w_ram_q;

    logic                  r_s1_vld;
    logic [PORT_WIDTH-1:0] r_s1_port;

    for (genvar k = 0; k < PORT_NUM; k++) begin : g_queue
        logic                  w_whit;
        logic                  w_rhit;
        logic [LVL_WIDTH-1:0]  w_lvl_nxt;
        logic [QDEPTH_BIT-1:0] r_wptr;
        logic [QDEPTH_BIT-1:0] r_rptr;
        logic [LVL_WIDTH-1:0]  r_lvl;
        logic                  r_ef;
        logic                  r_af;
        logic                  r_ff;
        logic                  r_ovf;
        logic                  r_udf;

        // Out-of-range port numbers never match any k, so they fall away here
        assign w_whit    = wr && (wport == PORT_WIDTH'(k));
        assign w_rhit    = rd && (rport == PORT_WIDTH'(k));
        assign w_wacc[k] = w_whit && !r_ff && !flush[k];
        assign w_racc[k] = w_rhit && !r_ef && !flush[k];

        always_comb begin
            w_lvl_nxt = r_lvl;
            if (flush[k]) begin
                w_lvl_nxt = '0;
            end else if (w_wacc[k] && !w_racc[k]) begin
                w_lvl_nxt = r_lvl + LVL_WIDTH'(1);
            end else if (!w_wacc[k] && w_racc[k]) begin
                w_lvl_nxt = r_lvl - LVL_WIDTH'(1);
            end
        end

        always_ff @(posedge clks) begin
            if (reset) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_lvl  <= '0;
                r_ef   <= 1'b1;
                r_af   <= 1'b0;
                r_ff   <= 1'b0;
                r_ovf  <= 1'b0;
                r_udf  <= 1'b0;
            end else begin
                if (flush[k]) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_ovf  <= 1'b0;
                    r_udf  <= 1'b0;
                end else begin
                    if (w_wacc[k])     r_wptr <= r_wptr + QDEPTH_BIT'(1);
                    if (w_racc[k])     r_rptr <= r_rptr + QDEPTH_BIT'(1);
                    if (w_whit && r_ff) r_ovf <= 1'b1;
                    if (w_rhit && r_ef) r_udf <= 1'b1;
                end
                r_lvl <= w_lvl_nxt;
                r_ef  <= (w_lvl_nxt == '0);
                r_ff  <= (w_lvl_nxt == LVL_WIDTH'(c_DEPTH));
                r_af  <= (w_lvl_nxt >= LVL_WIDTH'(AF_LEVEL));
            end
        end

        assign w_wptr[k]    = r_wptr;
        assign w_rptr[k]    = r_rptr;
        assign ef[k]        = r_ef;
        assign af[k]        = r_af;
        assign ff[k]        = r_ff;
        assign overflow[k]  = r_ovf;
        assign underflow[k] = r_udf;
        assign level[lvl_lsb(k, LVL_WIDTH) +: LVL_WIDTH] = r_lvl;
    end

    // At most one queue can accept per direction, so the OR-mux is exclusive
    always_comb begin
        w_ram_we    = |w_wacc;
        w_ram_re    = |w_racc;
        w_ram_waddr = '0;
        w_ram_raddr = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (w_wacc[k]) w_ram_waddr = {PORT_WIDTH'(k), w_wptr[k]};
            if (w_racc[k]) w_ram_raddr = {PORT_WIDTH'(k), w_rptr[k]};
        end
    end

    sdpramb_dclk #(
        .WADDR      (c_AW),
        .RADDR      (c_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_wclk  (clks),
        .i_wen   (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (wdata),
        .i_rclk  (clks),
        .i_ren   (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clks) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_port <= '0;
            rvld      <= 1'b0;
            rvld_port <= '0;
        end else begin
            r_s1_vld  <= w_ram_re;
            r_s1_port <= rport;
            rvld      <= r_s1_vld;
            if (r_s1_vld) rvld_port <= r_s1_port;
        end
    end

    always_ff @(posedge clks) begin
        if (r_s1_vld) rdata <= w_ram_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mque_pff.sv
// =============================================================================
// Module      : tb_mque_pff
// Description : Self-checking bench for mque_pff with a queue-based reference.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mque_pff;

    localparam int DW    = 72;
    localparam int PW    = 2;
    localparam int PN    = 4;
    localparam int LW    = 8;
    localparam int DEPTH = 128;

    logic            clks;
    logic            reset;
    logic            wr;
    logic [PW-1:0]   wport;
    logic [DW-1:0]   wdata;
    logic            rd;
    logic [PW-1:0]   rport;
    logic [PN-1:0]   flush;
    logic [DW-1:0]   rdata;
    logic            rvld;
    logic [PW-1:0]   rvld_port;
    logic [PN-1:0]   ef, af, ff, overflow, underflow;
    logic [LW*PN-1:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    mque_pff #(
        .DATA_WIDTH (DW),
        .PORT_WIDTH (PW),
        .PORT_NUM   (PN),
        .QDEPTH_BIT (7)
    ) dut (
        .clks      (clks),
        .reset     (reset),
        .wr        (wr),
        .wport     (wport),
        .wdata     (wdata),
        .rd        (rd),
        .rport     (rport),
        .flush     (flush),
        .rdata     (rdata),
        .rvld      (rvld),
        .rvld_port (rvld_port),
        .ef        (ef),
        .af        (af),
        .ff        (ff),
        .overflow  (overflow),
        .underflow (underflow),
        .level     (level)
    );

    initial clks = 1'b0;
    always #5 clks = ~clks;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef logic [DW-1:0] word_q_t [$];
    word_q_t       mq [PN];
    bit            m_ovf [PN];
    bit            m_udf [PN];
    bit            p1_v, e_v;
    logic [PW-1:0] p1_port, e_port;
    logic [DW-1:0] p1_d, e_d;

    always @(posedge clks) begin : model_step
        int sz [PN];
        if (reset) begin
            for (int q = 0; q < PN; q++) begin
                mq[q].delete();
                m_ovf[q] = 0;
                m_udf[q] = 0;
            end
            p1_v   = 0;
            e_v    = 0;
            e_port = '0;
        end else begin
            e_v = p1_v;
            if (p1_v) begin
                e_port = p1_port;
                e_d    = p1_d;
            end
            p1_v = 0;
            for (int q = 0; q < PN; q++) sz[q] = mq[q].size();
            if (rd && !flush[rport]) begin
                if (sz[rport] == 0) m_udf[rport] = 1;
                else begin
                    p1_d    = mq[rport].pop_front();
                    p1_v    = 1;
                    p1_port = rport;
                end
            end
            if (wr && !flush[wport]) begin
                if (sz[wport] == DEPTH) m_ovf[wport] = 1;
                else mq[wport].push_back(wdata);
            end
            for (int q = 0; q < PN; q++) begin
                if (flush[q]) begin
                    mq[q].delete();
                    m_ovf[q] = 0;
                    m_udf[q] = 0;
                end
            end
        end
    end

    always @(negedge clks) begin : compare
        logic [PN-1:0]    xe, xa, xf, xo, xu;
        logic [LW*PN-1:0] xl;
        for (int q = 0; q < PN; q++) begin
            xe[q] = (mq[q].size() == 0);
            xf[q] = (mq[q].size() == DEPTH);
            xa[q] = (mq[q].size() >= DEPTH - 16);
            xo[q] = m_ovf[q];
            xu[q] = m_udf[q];
            xl[q*LW +: LW] = LW'(mq[q].size());
        end
        chk("rvld", rvld, e_v);
        if (e_v) begin
            chk("rvld_port", rvld_port, e_port);
            chk("rdata", rdata, e_d);
        end
        chk("ef", ef, xe);
        chk("af", af, xa);
        chk("ff", ff, xf);
        chk("overflow", overflow, xo);
        chk("underflow", underflow, xu);
        chk("level", level, xl);
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit w, input int wp, input logic [DW-1:0] wd,
                        input bit r, input int rp, input logic [PN-1:0] fl);
        wr    = w;
        wport = wp[PW-1:0];
        wdata = wd;
        rd    = r;
        rport = rp[PW-1:0];
        flush = fl;
        @(posedge clks);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0);
    endtask

    function automatic logic [LW-1:0] lvl(input int q);
        return level[q*LW +: LW];
    endfunction

    initial begin
        reset = 1'b1;
        wr = 0; wport = '0; wdata = '0; rd = 0; rport = '0; flush = '0;
        idle(3);
        chk("rst_ef", ef, 4'hF);
        chk("rst_level", level, '0);
        chk("rst_rvld", rvld, 1'b0);
        chk("rst_rvld_port", rvld_port, '0);
        reset = 1'b0;
        idle(1);

        // five words through queue 2
        for (int i = 0; i < 5; i++) step(1, 2, DW'(100 + i), 0, 0, '0);
        chk("q2_level5", lvl(2), 8'd5);
        chk("q2_ef", ef, 4'b1011);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 2, '0);
        idle(3);
        chk("q2_ef_after", ef[2], 1'b1);

        // queue 0: offset pointers, fill to full, overflow, drain across wrap
        for (int i = 0; i < 3; i++) step(1, 0, DW'(i), 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0, '0);
        idle(2);
        for (int i = 0; i < DEPTH; i++) step(1, 0, {8'hA5, 64'(i * 7919)}, 0, 0, '0);
        chk("q0_ff", ff[0], 1'b1);
        chk("q0_level128", lvl(0), 8'd128);
        step(1, 0, DW'(72'hDEAD), 0, 0, '0);
        chk("q0_overflow", overflow[0], 1'b1);
        chk("q0_level_hold", lvl(0), 8'd128);
        for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1, 0, '0);
        idle(3);
        chk("q0_ef_drained", ef[0], 1'b1);

        // underflow on queue 1, sticky, then flush
        step(0, 0, '0, 1, 1, '0);
        chk("q1_underflow", underflow[1], 1'b1);
        idle(2);
        chk("q1_underflow_sticky", underflow[1], 1'b1);
        step(0, 0, '0, 0, 0, 4'b0010);
        chk("q1_underflow_clr", underflow[1], 1'b0);

        // queue 3 near almost-full
        for (int i = 0; i < 111; i++) step(1, 3, DW'(3000 + i), 0, 0, '0);
        chk("q3_level111", lvl(3), 8'd111);
        step(1, 3, DW'(5000), 1, 3, '0);
        chk("q3_level_rw", lvl(3), 8'd111);
        chk("q3_af0", af[3], 1'b0);
        step(1, 3, DW'(5001), 0, 0, '0);
        chk("q3_af1", af[3], 1'b1);
        chk("q3_level112", lvl(3), 8'd112);

        // flush priority on queue 0; queue 1 untouched
        for (int i = 0; i < 10; i++) step(1, 0, DW'(7000 + i), 0, 0, '0);
        step(1, 1, DW'(72'h111), 0, 0, '0);
        step(1, 1, DW'(72'h222), 0, 0, '0);
        chk("q0_level10", lvl(0), 8'd10);
        step(1, 0, DW'(72'hBAD), 1, 0, 4'b0001);
        chk("flush_level", lvl(0), 8'd0);
        chk("flush_ef", ef[0], 1'b1);
        chk("flush_ovf", overflow[0], 1'b0);
        chk("flush_udf", underflow[0], 1'b0);
        chk("flush_q1_level", lvl(1), 8'd2);
        idle(3);
        for (int i = 0; i < 2; i++) step(0, 0, '0, 1, 1, '0);
        idle(3);

        // concurrent write q1 / read q3
        for (int i = 0; i < 4; i++) step(1, 1, DW'(9000 + i), 1, 3, '0);
        idle(3);

        // reset with reads in flight
        step(0, 0, '0, 1, 3, '0);
        step(0, 0, '0, 1, 3, '0);
        reset = 1'b1;
        step(0, 0, '0, 1, 3, '0);
        chk("mid_rst_rvld", rvld, 1'b0);
        chk("mid_rst_ef", ef, 4'hF);
        chk("mid_rst_af", af, 4'h0);
        chk("mid_rst_level", level, '0);
        chk("mid_rst_ovf", overflow, 4'h0);
        reset = 1'b0;
        idle(2);
        step(1, 1, DW'(72'h5A5A), 0, 0, '0);
        step(0, 0, '0, 1, 1, '0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
